// File: rtl/dev_int_pkg.sv
// Shared constants, FSM state type and width helpers for the device interrupt controller.
package dev_int_pkg;

  localparam int unsigned CSR_ENA = 4;
  localparam int unsigned CSR_OF  = 3;
  localparam int unsigned CSR_DBA = 2;
  localparam int unsigned CSR_IO  = 1;
  localparam int unsigned CSR_IE  = 0;

  // Wide enough for the largest legal ack timeout (255).
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArb    = 2'd1,
    StAssert = 2'd2,
    StHold   = 2'd3
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned vec_of(input int unsigned base, input int unsigned idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/dev_int_pick.sv
// Combinational request picker: first pending slot at or after start, wrapping modulo NUM_DEV.
module dev_int_pick
  import dev_int_pkg::*;
#(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] pend,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   win,
  output logic               valid
);

  localparam logic [IDX_W:0] NDEV = (IDX_W+1)'(NUM_DEV);

  logic [NUM_DEV-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so that the start slot lands at bit 0, then take the lowest set bit.
  assign rot = NUM_DEV'({pend, pend} >> start);

  always_comb begin
    off   = '0;
    valid = 1'b0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

  assign sum = {1'b0, start} + {1'b0, off};
  assign win = IDX_W'((sum >= NDEV) ? (sum - NDEV) : sum);

endmodule

// File: rtl/dev_int_ctrl.sv
// Device interrupt controller: latches CSR request edges and schedules them onto one CPU irq.
// Define DEV_INT_RR_EN for round-robin arbitration; otherwise the lowest slot wins.
module dev_int_ctrl
  import dev_int_pkg::*;
#(
  parameter int unsigned NUM_DEV  = 4,
  parameter int unsigned VEC_W    = 4,
  parameter int unsigned VEC_BASE = 8,
  parameter int unsigned ACK_TMO  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_DEV*8-1:0] csr_i,
  input  logic                 gie_i,
  input  logic                 irq_ack_i,
  output logic                 irq_o,
  output logic [VEC_W-1:0]     irq_vec_o,
  output logic [NUM_DEV-1:0]   dev_svc_o,
  output logic [NUM_DEV-1:0]   pend_o,
  output logic                 tmo_o
);

  localparam int unsigned     IDX_W    = idx_w(NUM_DEV);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(ACK_TMO);

  state_e             state_q, state_d;
  logic [NUM_DEV-1:0] req, req_q, pend_q, pend_d, clr, svc_q, svc_d, win_oh;
  logic [IDX_W-1:0]   win_q, win_d, pick_win, ptr;
  logic               pick_valid, irq_q, irq_d, tmo_q, tmo_d, expire;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_DEV*4-1:0] csr_spare;
  logic               unused_csr;

  always_comb begin
    req       = '0;
    csr_spare = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      req[d] = csr_i[8*d+CSR_ENA] & csr_i[8*d+CSR_IE] &
               (csr_i[8*d+CSR_DBA] | csr_i[8*d+CSR_OF]);
      csr_spare[4*d +: 4] = {csr_i[8*d+5 +: 3], csr_i[8*d+CSR_IO]};
    end
  end
  assign unused_csr = ^csr_spare;

  assign win_oh = NUM_DEV'(1) << win_q;
  assign expire = (cnt_q == CNT_W'(1));
  // A fresh edge in the service cycle re-arms the slot, so set beats clear.
  assign pend_d = (pend_q & ~clr) | (req & ~req_q);

`ifdef DEV_INT_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StAssert && (irq_ack_i || expire)) begin
      ptr_d = (win_q == IDX_W'(NUM_DEV - 1)) ? '0 : win_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  dev_int_pick #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pend  (pend_q),
    .start (ptr),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    svc_d   = '0;
    clr     = '0;
    case (state_q)
      StIdle: begin
        if (gie_i && |pend_q) state_d = StArb;
      end
      StArb: begin
        if (pick_valid) begin
          win_d   = pick_win;
          irq_d   = 1'b1;
          vec_d   = VEC_W'(vec_of(VEC_BASE, 32'(pick_win)));
          cnt_d   = TMO_LOAD;
          state_d = StAssert;
        end else begin
          state_d = StIdle;
        end
      end
      StAssert: begin
        if (irq_ack_i) begin
          irq_d   = 1'b0;
          svc_d   = win_oh;
          clr     = win_oh;
          state_d = StHold;
        end else if (expire) begin
          irq_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHold: begin
        if (!irq_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= '0;
      pend_q  <= '0;
      win_q   <= '0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      svc_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      win_q   <= win_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      svc_q   <= svc_d;
    end
  end

  assign irq_o     = irq_q;
  assign irq_vec_o = vec_q;
  assign dev_svc_o = svc_q;
  assign pend_o    = pend_q;
  assign tmo_o     = tmo_q;

endmodule
